// File: rtl/trace_capture_if.sv
// Sample-in and readout-out bus of the trace capture block.
// The master side is the core/debug host; the slave side is trace_capture.
interface trace_capture_if #(
  parameter int unsigned PC_W = 32,
  parameter int unsigned IR_W = 32
);
  logic                 sample_valid;
  logic [PC_W-1:0]      pc;
  logic [IR_W-1:0]      ir;
  logic                 out_valid;
  logic                 out_ready;
  logic [PC_W+IR_W-1:0] out_data;

  modport master (
    output sample_valid, pc, ir, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  sample_valid, pc, ir, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/trace_capture.sv
// Instruction trace capture: circular pc/ir buffer with PC-match or forced trigger,
// a fixed number of post-trigger entries, and oldest-first valid/ready readout.
module trace_capture #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned IR_W      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  trace_capture_if.slave           bus,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     force_trig,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic [$clog2(DEPTH)-1:0] trig_pos,
  output logic                     wrapped
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = PC_W + IR_W;
  localparam logic [AW:0]   FullCnt  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PostInit = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic [AW:0]       rd_idx_q, rd_idx_d;
  logic [AW-1:0]     post_cnt_q, post_cnt_d;
  logic [AW-1:0]     trig_pos_q, trig_pos_d;
  logic              wrapped_q, wrapped_d;
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;

  logic [DW-1:0]     mem [DEPTH];
  logic              wr_en;
  logic              trigger;
  logic [AW:0]       fill_inc;
  logic [AW-1:0]     rd_addr;

  assign trigger  = bus.sample_valid && (force_trig || (trig_en && bus.pc == trig_pc));
  assign fill_inc = (fill_q == FullCnt) ? fill_q : fill_q + 1'b1;
  // Oldest entry sits fill_count slots behind the write pointer.
  assign rd_addr  = wr_ptr_q - fill_q[AW-1:0] + rd_idx_q[AW-1:0];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    rd_idx_d    = rd_idx_q;
    post_cnt_d  = post_cnt_q;
    trig_pos_d  = trig_pos_q;
    wrapped_d   = wrapped_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wr_en       = 1'b0;

    if (arm) begin
      // Restart from any state; a coincident sample is dropped.
      state_d     = StArmed;
      wr_ptr_d    = '0;
      fill_d      = '0;
      rd_idx_d    = '0;
      post_cnt_d  = '0;
      wrapped_d   = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StArmed: begin
          if (bus.sample_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = fill_inc;
            if (fill_q == FullCnt) wrapped_d = 1'b1;
            if (trigger) begin
              trig_pos_d = AW'(fill_inc - 1'b1);
              if (POST_TRIG == 0) begin
                state_d = StDone;
              end else begin
                state_d    = StPost;
                post_cnt_d = PostInit;
              end
            end
          end
        end
        StPost: begin
          if (bus.sample_valid) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fill_d     = fill_inc;
            post_cnt_d = post_cnt_q - 1'b1;
            // Overwriting the oldest entry moves the trigger one slot closer to the head.
            if (fill_q == FullCnt && trig_pos_q != '0) trig_pos_d = trig_pos_q - 1'b1;
            if (post_cnt_q == AW'(1)) state_d = StDone;
          end
        end
        StDone: begin
          if (!out_valid_q || bus.out_ready) begin
            if (rd_idx_q < fill_q) begin
              out_valid_d = 1'b1;
              out_data_d  = mem[rd_addr];
              rd_idx_d    = rd_idx_q + 1'b1;
            end else begin
              out_valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      rd_idx_q    <= '0;
      post_cnt_q  <= '0;
      trig_pos_q  <= '0;
      wrapped_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      rd_idx_q    <= rd_idx_d;
      post_cnt_q  <= post_cnt_d;
      trig_pos_q  <= trig_pos_d;
      wrapped_q   <= wrapped_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= {bus.pc, bus.ir};
  end

  assign state         = state_q;
  assign fill_count    = fill_q;
  assign trig_pos      = trig_pos_q;
  assign wrapped       = wrapped_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_trace_capture.sv
// Randomised bench for trace_capture: a queue of every written sample is the reference;
// expected buffer contents, fill, trigger position and wrap flag are derived from it.
module tb_trace_capture;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0, trig_en = 1'b0, force_trig = 1'b0;
  logic [31:0] trig_pc = '0;
  logic [1:0]  state;
  logic [4:0]  fill_count;
  logic [3:0]  trig_pos;
  logic        wrapped;

  logic        arm0 = 1'b0, force0 = 1'b0;
  logic [1:0]  state0;
  logic [4:0]  fill0;
  logic [3:0]  tpos0;
  logic        wrapped0;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] wr_q[$];
  int          t_idx;

  trace_capture_if #(.PC_W(32), .IR_W(32)) bus ();
  trace_capture_if #(.PC_W(32), .IR_W(32)) bus0 ();

  trace_capture #(.PC_W(32), .IR_W(32), .DEPTH(16), .POST_TRIG(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .arm        (arm),
    .trig_en    (trig_en),
    .trig_pc    (trig_pc),
    .force_trig (force_trig),
    .state      (state),
    .fill_count (fill_count),
    .trig_pos   (trig_pos),
    .wrapped    (wrapped)
  );

  trace_capture #(.PC_W(32), .IR_W(32), .DEPTH(16), .POST_TRIG(0)) dut0 (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus0),
    .arm        (arm0),
    .trig_en    (1'b0),
    .trig_pc    (32'h0),
    .force_trig (force0),
    .state      (state0),
    .fill_count (fill0),
    .trig_pos   (tpos0),
    .wrapped    (wrapped0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Arm, n_pre samples, trigger sample, 8 post samples; pc = pc_base + 4*i.
  task automatic capture(input int n_pre, input bit use_force, input logic [31:0] pc_base);
    int n, fill, tp;
    wr_q.delete();
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("armed_state", state, 1);
    check("armed_fill", fill_count, 0);
    trig_pc = pc_base + 32'(4 * n_pre);
    trig_en = !use_force;
    for (int i = 0; i < n_pre + 1 + 8; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.sample_valid = 1'b0;
        bus.pc = trig_pc;
        force_trig = 1'($urandom_range(0, 1));
        step();
      end
      bus.sample_valid = 1'b1;
      bus.pc = pc_base + 32'(4 * i);
      bus.ir = $urandom;
      // Triggers during the post phase must be ignored.
      force_trig = (use_force && i == n_pre) || (i > n_pre && $urandom_range(0, 1) == 1);
      wr_q.push_back({bus.pc, bus.ir});
      if (i == n_pre) t_idx = i;
      step();
      if (i == n_pre) check("post_state", state, 2);
    end
    bus.sample_valid = 1'b0;
    force_trig = 1'b0;
    n = wr_q.size();
    fill = (n > 16) ? 16 : n;
    tp = t_idx - (n - fill);
    if (tp < 0) tp = 0;
    check("done_state", state, 3);
    check("done_first_valid", bus.out_valid, 0);
    check("fill_count", fill_count, 64'(fill));
    check("trig_pos", trig_pos, 64'(tp));
    check("wrapped", wrapped, (t_idx + 1 > 16) ? 1 : 0);
  endtask

  task automatic readout(input bit toggle, output logic [31:0] first_pc,
                         output logic [31:0] last_pc);
    int n, fill, s, k, gaps, cyc;
    bit started, r;
    n = wr_q.size();
    fill = (n > 16) ? 16 : n;
    s = n - fill;
    k = 0; gaps = 0; cyc = 0; started = 0;
    first_pc = '0; last_pc = '0;
    while (k < fill && cyc < 400) begin
      r = toggle ? cyc[0] : 1'($urandom_range(0, 1));
      bus.out_ready = r;
      if (bus.out_valid) begin
        started = 1;
        check("out_data", bus.out_data, wr_q[s + k]);
        if (k == 0) first_pc = bus.out_data[63:32];
        last_pc = bus.out_data[63:32];
        if (r) k++;
      end else if (started) begin
        gaps++;
      end
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("read_count", 64'(k), 64'(fill));
    check("read_gaps", 64'(gaps), 0);
    repeat (2) step();
    check("drained_valid", bus.out_valid, 0);
    check("drained_state", state, 3);
  endtask

  initial begin
    logic [31:0] fpc, lpc;
    int k, cyc;
    logic [63:0] s0[$];
    bus.sample_valid = 1'b0; bus.pc = '0; bus.ir = '0; bus.out_ready = 1'b0;
    bus0.sample_valid = 1'b0; bus0.pc = '0; bus0.ir = '0; bus0.out_ready = 1'b0;

    #1;
    check("rst_state", state, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_fill", fill_count, 0);
    check("rst_trig_pos", trig_pos, 0);
    check("rst_wrapped", wrapped, 0);
    #12 reset = 1'b1;
    step();

    // Samples in IDLE are ignored.
    bus.sample_valid = 1'b1; bus.pc = 32'h40; force_trig = 1'b1;
    step();
    bus.sample_valid = 1'b0; force_trig = 1'b0;
    check("idle_state", state, 0);
    check("idle_fill", fill_count, 0);

    // Basic PC-match capture with alternating ready.
    capture(4, 0, 32'h0);
    check("c42_fill", fill_count, 13);
    check("c42_trig_pos", trig_pos, 4);
    check("c42_wrapped", wrapped, 0);
    readout(1, fpc, lpc);
    check("c42_first_pc", fpc, 32'h0);
    check("c42_last_pc", lpc, 32'h30);

    // Wrapped pre-trigger capture.
    capture(30, 0, 32'h0);
    check("c43_fill", fill_count, 16);
    check("c43_wrapped", wrapped, 1);
    check("c43_trig_pos", trig_pos, 7);
    readout(0, fpc, lpc);
    check("c43_first_pc", fpc, 32'h5C);
    check("c43_last_pc", lpc, 32'h98);

    // Re-arm during POST, with a coincident sample that must not be written.
    arm = 1'b1; step(); arm = 1'b0;
    trig_en = 1'b1; trig_pc = 32'hC;
    for (int i = 0; i < 7; i++) begin
      bus.sample_valid = 1'b1; bus.pc = 32'(4 * i); bus.ir = $urandom;
      step();
    end
    check("rearm_pre_state", state, 2);
    arm = 1'b1; bus.pc = 32'h100;
    step();
    arm = 1'b0; bus.sample_valid = 1'b0;
    check("rearm_state", state, 1);
    check("rearm_fill", fill_count, 0);

    // Randomised captures, each re-arming from DONE.
    for (int sc = 0; sc < 8; sc++) begin
      capture($urandom_range(0, 40), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
      readout(1'($urandom_range(0, 1)), fpc, lpc);
    end

    // Reset mid-readout acts immediately.
    capture(6, 1, 32'h2000);
    step(); step();
    check("mid_valid", bus.out_valid, 1);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_fill", fill_count, 0);
    check("mid_rst_data", bus.out_data, 0);
    #1 reset = 1'b1;
    step();

    // POST_TRIG = 0: forced trigger on the 3rd sample ends capture on that edge.
    arm0 = 1'b1; step(); arm0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus0.sample_valid = 1'b1; bus0.pc = $urandom; bus0.ir = $urandom;
      force0 = (i == 2);
      s0.push_back({bus0.pc, bus0.ir});
      step();
      if (i == 1) check("pt0_armed", state0, 1);
    end
    bus0.sample_valid = 1'b0; force0 = 1'b0;
    check("pt0_state", state0, 3);
    check("pt0_fill", fill0, 3);
    check("pt0_trig_pos", tpos0, 2);
    check("pt0_wrapped", wrapped0, 0);
    bus0.out_ready = 1'b1;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 20) begin
      if (bus0.out_valid) begin
        check("pt0_data", bus0.out_data, s0[k]);
        k++;
      end
      step();
      cyc++;
    end
    check("pt0_count", 64'(k), 3);
    check("pt0_drained", bus0.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter PC_W, 32, width of the captured program counter.
REQ-002 Parameter IR_W, 32, width of the captured instruction word.
REQ-003 Parameter DEPTH, 16, number of trace entries; power of two, at least 4.
REQ-004 Parameter POST_TRIG, 8, entries captured after the trigger entry; range 0..DEPTH-1.
REQ-005 Port: clock, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port: reset, input, 1, asynchronous active-low reset.
REQ-007 Port: sample_valid, input, 1, a pc/ir sample is present this cycle (instruction-fetch strobe).
REQ-008 Port: pc, input, PC_W, program counter sample.
REQ-009 Port: ir, input, IR_W, instruction register sample.
REQ-010 Port: arm, input, 1, single-cycle pulse that starts a new capture.
REQ-011 Port: trig_en, input, 1, enables the PC-match trigger.
REQ-012 Port: trig_pc, input, PC_W, PC value that fires the trigger.
REQ-013 Port: force_trig, input, 1, unconditional trigger on the current sample.
REQ-014 Port: out_ready, input, 1, readout consumer accepts out_data.
REQ-015 Port: out_valid, output, 1, out_data holds a valid entry.
REQ-016 Port: out_data, output, PC_W+IR_W, entry {pc, ir}, oldest entry first.
REQ-017 Port: state, output, 2, IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-018 Port: fill_count, output, clog2(DEPTH)+1, valid entries held; saturates at DEPTH.
REQ-019 Port: trig_pos, output, clog2(DEPTH), index of the trigger entry counted from the oldest entry.
REQ-020 Port: wrapped, output, 1, at least one entry was overwritten during pre-trigger capture.

Function
REQ-021 Storage shall be a DEPTH-entry circular buffer with write pointer wr_ptr, which wraps modulo DEPTH.
REQ-022 IDLE: samples ignored; arm goes to ARMED and clears wr_ptr, fill_count, wrapped and the read index.
REQ-023 ARMED: each sample_valid writes {pc, ir} at wr_ptr and increments wr_ptr; fill_count increments and saturates at DEPTH; writing while fill_count==DEPTH sets wrapped.
REQ-024 Trigger condition: sample_valid && (force_trig || (trig_en && pc==trig_pc)) while in ARMED; the triggering sample shall be written.
REQ-025 On trigger, trig_pos shall latch fill_count-1 after the write, with saturation applied.
REQ-026 On trigger with POST_TRIG==0: go to DONE on the next edge.
REQ-027 On trigger otherwise: go to POST with post_cnt=POST_TRIG.
REQ-028 POST: each sample_valid writes an entry and decrements post_cnt; the write that brings post_cnt to 0 goes to DONE.
REQ-029 POST: trigger conditions shall be ignored.
REQ-030 POST writes over the oldest entries once fill_count==DEPTH; trig_pos shall then decrement per overwrite, floor 0.
REQ-031 DONE: no writes.
REQ-032 DONE: out_valid=1 while read index < fill_count; out_data = buffer[(wr_ptr - fill_count + read index) mod DEPTH].
REQ-033 DONE: out_valid && out_ready advances the read index by 1.
REQ-034 DONE: after the last entry is read, out_valid=0 and the block stays in DONE.
REQ-035 out_data shall be registered; it holds stable while out_valid && !out_ready.
REQ-036 arm in ARMED, POST or DONE shall restart capture exactly as in REQ-022, and a sample in the same cycle shall not be written.
REQ-037 out_valid shall be 0 in every state other than DONE.
REQ-038 Latency: a sample is readable only in DONE; the first out_valid occurs one cycle after entry to DONE.

Reset
REQ-039 reset low shall immediately force state=IDLE, out_valid=0, out_data=0, fill_count=0, trig_pos=0, wrapped=0, wr_ptr=0 and post_cnt=0.
REQ-040 Buffer contents need not be reset.
REQ-041 Reset asserted mid-capture or mid-readout shall abandon the operation with no further writes or reads.

Verification
REQ-042 DEPTH=16, POST_TRIG=8: arm, 5 samples pc=0x00..0x10 step 4, trig_pc=0x10 on 5th, then 8 samples -> DONE, fill_count=13, trig_pos=4, wrapped=0, readout 13 entries pc 0x00..0x30 in order.
REQ-043 DEPTH=16, POST_TRIG=8: 30 pre-trigger samples pc=4*i, trigger on i=30, then 8 samples -> fill_count=16, wrapped=1, first out pc=0x5C, last pc=0x98, trig_pos=7.
REQ-044 POST_TRIG=0, force_trig on 3rd sample -> DONE next edge, fill_count=3, trig_pos=2.
REQ-045 Readout with out_ready toggling every other cycle -> each entry is presented exactly once, out_data stable while stalled, no gaps or duplicates.
REQ-046 Re-arm in POST after 3 post samples -> state=ARMED, fill_count=0; reset pulled low mid-readout -> state=IDLE and out_valid=0 in the same cycle.
